// File: rtl/gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// gpio_irq_pkg
// Shared definitions for the GPIO / interrupt controller:
//   - register addresses on the 4-bit register bus
//   - interrupt mode encoding {MODE1, MODE0}
//   - vector FSM state type
//   - pin_event(): per-pin event detector for a given mode
// Optional debounce hardware is selected by the GPIO_IRQ_DEBOUNCE_EN macro
// (see gpio_irq_ctrl.sv); nothing in this package depends on it.
// -----------------------------------------------------------------------------
package gpio_irq_pkg;

   localparam logic [3:0] ADDR_OUT      = 4'd0;
   localparam logic [3:0] ADDR_DIR      = 4'd1;
   localparam logic [3:0] ADDR_INV      = 4'd2;
   localparam logic [3:0] ADDR_DEB_EN   = 4'd3;
   localparam logic [3:0] ADDR_IRQ_EN   = 4'd4;
   localparam logic [3:0] ADDR_MODE0    = 4'd5;
   localparam logic [3:0] ADDR_MODE1    = 4'd6;
   localparam logic [3:0] ADDR_PEND     = 4'd7;
   localparam logic [3:0] ADDR_IN       = 4'd8;
   localparam logic [3:0] ADDR_RAW      = 4'd9;
   localparam logic [3:0] ADDR_VEC_BASE = 4'd10;
   localparam logic [3:0] ADDR_DEB_THR  = 4'd11;

   localparam logic [1:0] MODE_RISE  = 2'b00;
   localparam logic [1:0] MODE_FALL  = 2'b01;
   localparam logic [1:0] MODE_BOTH  = 2'b10;
   localparam logic [1:0] MODE_LEVEL = 2'b11;

   // Pin index width; enough for up to 32 pins.
   localparam int IDX_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } irq_state_t;

   // Event for one pin given its mode, current IN value and previous IN value.
   function automatic logic pin_event(input logic [1:0] mode, input logic cur, input logic prev);
      logic hit;
      case (mode)
         MODE_RISE:  hit = cur & ~prev;
         MODE_FALL:  hit = ~cur & prev;
         MODE_BOTH:  hit = cur ^ prev;
         default:    hit = cur;          // level-high: fires every cycle while high
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/gpio_irq_debounce.sv
// -----------------------------------------------------------------------------
// gpio_irq_debounce
// One debounce channel. A change on cond_i must persist for a threshold number
// of debounce ticks before stable_o follows it.
// Ports:
//   sysclk, reset : clock, asynchronous active-high reset
//   cond_i        : synchronised, polarity-corrected input
//   tick_i        : one-cycle debounce tick
//   en_i          : channel enable; while low stable_o tracks cond_i
//   thr_i         : tick threshold (0 behaves as 1)
//   stable_o      : debounced value
// Only instantiated when GPIO_IRQ_DEBOUNCE_EN is defined.
// -----------------------------------------------------------------------------
module gpio_irq_debounce
   import gpio_irq_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             cond_i,
   input  logic             tick_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] thr_i,
   output logic             stable_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] thr_eff;
   logic [CNT_W:0]   cnt_inc;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      thr_eff  = (thr_i == '0) ? CNT_W'(1) : thr_i;
      cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
      if (!en_i) begin
         // Disabled: keep stable aligned so re-enabling causes no spurious edge.
         cnt_d    = '0;
         stable_d = cond_i;
      end else if (cond_i == stable_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_inc >= {1'b0, thr_eff}) begin
            stable_d = cond_i;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_irq_ctrl
// Register-mapped bank of WIDTH bidirectional pins with per-pin edge/level
// interrupts, W1C pending bits and a priority-encoded vector delivered through
// an irq / irq_ack handshake.
// Ports:
//   sysclk, reset       : clock, asynchronous active-high reset
//   pin_in              : raw asynchronous pad inputs
//   pin_out, pin_oe_n   : OUT register and inverted DIR register
//   debct_ping          : debounce tick
//   wr_n, rd_n, addr    : active-low write/read strobes, register select
//   din, dout           : write data, combinational read data (all ones idle)
//   irq, irq_vec        : interrupt request and VEC_BASE + pin index
//   irq_ack             : one-cycle acknowledge
// Macro GPIO_IRQ_DEBOUNCE_EN builds the debounce channels for the low DEB_CH
// pins; without it DEB_EN / DEB_THR read 0 and debct_ping is ignored.
// -----------------------------------------------------------------------------
module gpio_irq_ctrl
   import gpio_irq_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEB_CH    = 4,
   parameter int DEB_CNT_W = 4
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe_n,
   input  logic             debct_ping,
   input  logic             wr_n,
   input  logic             rd_n,
   input  logic [3:0]       addr,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   output logic             irq,
   output logic [7:0]       irq_vec,
   input  logic             irq_ack
);

   logic [WIDTH-1:0]     out_q, dir_q, inv_q, irq_en_q, mode0_q, mode1_q;
   logic [7:0]           vec_base_q;
   logic [WIDTH-1:0]     sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0]     pend_q, pend_d;
   logic [WIDTH-1:0]     cond, in_w, evt;
   logic [WIDTH-1:0]     pend_w1c, pend_ack, active;
   logic [WIDTH-1:0]     deb_en_w;
   logic [DEB_CNT_W-1:0] deb_thr_w;
   logic [31:0]          rdata;
   irq_state_t           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d, enc_idx;
   logic [7:0]           vec_q, vec_d;

   // ---------------- configuration registers ----------------
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         out_q      <= '0;
         dir_q      <= '0;
         inv_q      <= '0;
         irq_en_q   <= '0;
         mode0_q    <= '0;
         mode1_q    <= '0;
         vec_base_q <= '0;
      end else if (!wr_n) begin
         case (addr)
            ADDR_OUT:      out_q      <= din[WIDTH-1:0];
            ADDR_DIR:      dir_q      <= din[WIDTH-1:0];
            ADDR_INV:      inv_q      <= din[WIDTH-1:0];
            ADDR_IRQ_EN:   irq_en_q   <= din[WIDTH-1:0];
            ADDR_MODE0:    mode0_q    <= din[WIDTH-1:0];
            ADDR_MODE1:    mode1_q    <= din[WIDTH-1:0];
            ADDR_VEC_BASE: vec_base_q <= din[7:0];
            default: ;
         endcase
      end
   end

`ifdef GPIO_IRQ_DEBOUNCE_EN
   logic [WIDTH-1:0]     deb_en_q;
   logic [DEB_CNT_W-1:0] deb_thr_q;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         deb_en_q  <= '0;
         deb_thr_q <= '1;
      end else if (!wr_n) begin
         if (addr == ADDR_DEB_EN)  deb_en_q  <= din[WIDTH-1:0];
         if (addr == ADDR_DEB_THR) deb_thr_q <= din[DEB_CNT_W-1:0];
      end
   end

   assign deb_en_w  = deb_en_q;
   assign deb_thr_w = deb_thr_q;
`else
   logic unused_ping;
   assign unused_ping = debct_ping;
   assign deb_en_w    = '0;
   assign deb_thr_w   = '0;
`endif

   // ---------------- input path ----------------
   assign cond = sync2_q ^ inv_q;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_pin
         if (gi < DEB_CH) begin : g_deb
`ifdef GPIO_IRQ_DEBOUNCE_EN
            logic stable;
            gpio_irq_debounce #(.CNT_W(DEB_CNT_W)) u_deb (
               .sysclk   (sysclk),
               .reset    (reset),
               .cond_i   (cond[gi]),
               .tick_i   (debct_ping),
               .en_i     (deb_en_w[gi]),
               .thr_i    (deb_thr_w),
               .stable_o (stable)
            );
            assign in_w[gi] = deb_en_w[gi] ? stable : cond[gi];
`else
            assign in_w[gi] = cond[gi];
`endif
         end else begin : g_raw
            assign in_w[gi] = cond[gi];
         end
         assign evt[gi] = pin_event({mode1_q[gi], mode0_q[gi]}, in_w[gi], prev_q[gi]);
      end
   endgenerate

   // ---------------- pending bits ----------------
   assign pend_w1c = (!wr_n && addr == ADDR_PEND) ? din[WIDTH-1:0] : '0;
   assign pend_ack = (state_q == REQ && irq_ack) ? (WIDTH'(1) << idx_q) : '0;
   // A new event in the same cycle as a clear keeps the bit set.
   assign pend_d   = (pend_q & ~(pend_w1c | pend_ack)) | (evt & irq_en_q);

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
         prev_q  <= in_w;
         pend_q  <= pend_d;
      end
   end

   // ---------------- priority encoder (lowest index wins) ----------------
   assign active = pend_q & irq_en_q;

   always_comb begin
      enc_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (active[i]) enc_idx = i[IDX_W-1:0];
      end
   end

   // ---------------- vector FSM ----------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      case (state_q)
         IDLE: begin
            if (|active) begin
               idx_d   = enc_idx;
               vec_d   = vec_base_q + {{(8 - IDX_W){1'b0}}, enc_idx};
               state_d = REQ;
            end
         end
         REQ: begin
            // Held until acknowledged or withdrawn; later arrivals never preempt.
            if (irq_ack || !pend_q[idx_q] || !irq_en_q[idx_q]) state_d = GAP;
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
      end
   end

   assign irq     = (state_q == REQ);
   assign irq_vec = vec_q;

   // ---------------- read mux and pin outputs ----------------
   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_OUT:      rdata[WIDTH-1:0]     = out_q;
         ADDR_DIR:      rdata[WIDTH-1:0]     = dir_q;
         ADDR_INV:      rdata[WIDTH-1:0]     = inv_q;
         ADDR_DEB_EN:   rdata[WIDTH-1:0]     = deb_en_w;
         ADDR_IRQ_EN:   rdata[WIDTH-1:0]     = irq_en_q;
         ADDR_MODE0:    rdata[WIDTH-1:0]     = mode0_q;
         ADDR_MODE1:    rdata[WIDTH-1:0]     = mode1_q;
         ADDR_PEND:     rdata[WIDTH-1:0]     = pend_q;
         ADDR_IN:       rdata[WIDTH-1:0]     = in_w;
         ADDR_RAW:      rdata[WIDTH-1:0]     = sync2_q;
         ADDR_VEC_BASE: rdata[7:0]           = vec_base_q;
         ADDR_DEB_THR:  rdata[DEB_CNT_W-1:0] = deb_thr_w;
         default:       rdata                = '0;
      endcase
   end

   assign dout     = rd_n ? '1 : rdata;
   assign pin_out  = out_q;
   assign pin_oe_n = ~dir_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_irq_ctrl
// Directed scoreboard bench for gpio_irq_ctrl. Stimulus tasks push expected
// register reads, signal samples and interrupt vectors into queues; a monitor
// on the falling clock edge pops and compares them as the DUT presents them.
// Debounce expectations follow GPIO_IRQ_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_gpio_irq_ctrl;
   import gpio_irq_pkg::*;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] pin_in;
   logic [31:0] pin_out;
   logic [31:0] pin_oe_n;
   logic        debct_ping;
   logic        wr_n;
   logic        rd_n;
   logic [3:0]  addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;
   logic [7:0]  irq_vec;
   logic        irq_ack;

   gpio_irq_ctrl #(.WIDTH(32), .DEB_CH(4), .DEB_CNT_W(4)) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .pin_in     (pin_in),
      .pin_out    (pin_out),
      .pin_oe_n   (pin_oe_n),
      .debct_ping (debct_ping),
      .wr_n       (wr_n),
      .rd_n       (rd_n),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .irq        (irq),
      .irq_vec    (irq_vec),
      .irq_ack    (irq_ack)
   );

   always #5 sysclk = ~sysclk;

`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam logic [31:0] THR_RST = 32'h0000_000F;
`else
   localparam logic [31:0] THR_RST = 32'h0000_0000;
`endif

   // kind: 0 dout, 1 irq, 2 irq_vec, 3 pin_out, 4 pin_oe_n, 5 dout (idle)
   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } item_t;

   item_t      rd_q[$];
   item_t      sig_q[$];
   logic [7:0] irq_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         sample_cnt = 0;
   logic       irq_seen = 1'b0;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge sysclk);
      #1;
      sample_cnt = 0;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      wr_n = 1'b0;
      tick();
      wr_n = 1'b1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
      item_t it;
      it.kind = 0;
      it.exp  = e;
      it.name = nm;
      rd_q.push_back(it);
      addr = a;
      rd_n = 1'b0;
      tick();
      rd_n = 1'b1;
   endtask

   // Queue a signal sample for the current cycle (no clock advance).
   task automatic expect_sig(input int k, input logic [31:0] e, input string nm);
      item_t it;
      it.kind = k;
      it.exp  = e;
      it.name = nm;
      sig_q.push_back(it);
      sample_cnt = sample_cnt + 1;
   endtask

   task automatic chk(input int k, input logic [31:0] e, input string nm);
      expect_sig(k, e, nm);
      tick();
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic ping();
      debct_ping = 1'b1;
      tick();
      debct_ping = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge sysclk) begin : mon
      item_t       it;
      logic [31:0] act;
      logic [7:0]  ev;
      if (rd_n == 1'b0) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_errors++;
            $display("FAIL rd_unexpected: dout=%08h required no read", dout);
         end else begin
            it = rd_q.pop_front();
            if (dout !== it.exp) begin
               n_errors++;
               $display("FAIL %s: dout=%08h required %08h", it.name, dout, it.exp);
            end else begin
               $display("ok   %s: dout=%08h", it.name, dout);
            end
         end
      end
      for (int j = 0; j < sample_cnt; j++) begin
         if (sig_q.size() != 0) begin
            it = sig_q.pop_front();
            case (it.kind)
               1:       act = {31'b0, irq};
               2:       act = {24'b0, irq_vec};
               3:       act = pin_out;
               4:       act = pin_oe_n;
               default: act = dout;
            endcase
            n_checks++;
            if (act !== it.exp) begin
               n_errors++;
               $display("FAIL %s: got %08h required %08h", it.name, act, it.exp);
            end else begin
               $display("ok   %s: %08h", it.name, act);
            end
         end
      end
      if (irq === 1'b1 && !irq_seen) begin
         n_checks++;
         if (irq_q.size() == 0) begin
            n_errors++;
            $display("FAIL irq_unexpected: irq rose with irq_vec=%02h, none required", irq_vec);
         end else begin
            ev = irq_q.pop_front();
            if (irq_vec !== ev) begin
               n_errors++;
               $display("FAIL irq_rise_vec: irq_vec=%02h required %02h", irq_vec, ev);
            end else begin
               $display("ok   irq_rise_vec: %02h", irq_vec);
            end
         end
      end
      irq_seen = (irq === 1'b1);
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      reset      = 1'b1;
      pin_in     = '0;
      debct_ping = 1'b0;
      wr_n       = 1'b1;
      rd_n       = 1'b1;
      addr       = '0;
      din        = '0;
      irq_ack    = 1'b0;
      wait_n(3);
      reset = 1'b0;

      // Reset state
      for (int a = 0; a < 16; a++)
         rd(4'(a), (a == 11) ? THR_RST : 32'h0, $sformatf("reset_reg%0d", a));
      expect_sig(4, 32'hFFFF_FFFF, "reset_pin_oe_n");
      expect_sig(3, 32'h0, "reset_pin_out");
      expect_sig(1, 32'h0, "reset_irq");
      chk(2, 32'h0, "reset_irq_vec");
      chk(5, 32'hFFFF_FFFF, "dout_idle_ones");

      // Register basics
      wr(ADDR_OUT, 32'hA5A5_0001);
      wr(ADDR_DIR, 32'h0000_FFFF);
      expect_sig(3, 32'hA5A5_0001, "pin_out");
      chk(4, 32'hFFFF_0000, "pin_oe_n");
      rd(ADDR_DIR, 32'h0000_FFFF, "dir_readback");
      wr(4'd12, 32'h1234_5678);
      rd(4'd12, 32'h0, "reg12_reads_zero");
      wr(ADDR_INV, 32'h0000_0010);
      rd(ADDR_IN, 32'h0000_0010, "in_inverted");
      rd(ADDR_RAW, 32'h0, "raw_not_inverted");
      wr(ADDR_INV, 32'h0);
      ack();
      chk(1, 32'h0, "ack_in_idle_ignored");

      // Rising edge on pin 5
      wr(ADDR_IRQ_EN, 32'h0000_0020);
      wr(ADDR_VEC_BASE, 32'h0000_0040);
      pin_in[5] = 1'b1;
      irq_q.push_back(8'h45);
      rd(ADDR_PEND, 32'h0, "p5_pend_before_k");
      rd(ADDR_RAW, 32'h0, "p5_raw_after_k");
      rd(ADDR_RAW, 32'h0000_0020, "p5_raw_after_k1");
      expect_sig(1, 32'h0, "p5_irq_low_at_k2");
      rd(ADDR_PEND, 32'h0000_0020, "p5_pend_at_k2");
      expect_sig(1, 32'h1, "p5_irq_at_k3");
      expect_sig(2, 32'h45, "p5_vec_at_k3");
      tick();
      ack();
      expect_sig(1, 32'h0, "p5_irq_after_ack");
      rd(ADDR_PEND, 32'h0, "p5_pend_after_ack");
      wait_n(4);
      chk(1, 32'h0, "p5_no_reassert");
      pin_in[5] = 1'b0;

      // Priority and no-preempt
      wr(ADDR_IRQ_EN, 32'h0000_008A);
      pin_in[7] = 1'b1;
      pin_in[3] = 1'b1;
      irq_q.push_back(8'h43);
      irq_q.push_back(8'h41);
      irq_q.push_back(8'h47);
      wait_n(3);
      expect_sig(1, 32'h0, "pr_irq_low_at_k2");
      rd(ADDR_PEND, 32'h0000_0088, "pr_pend_7_3");
      expect_sig(2, 32'h43, "pr_vec_first");
      pin_in[1] = 1'b1;
      tick();
      wait_n(3);
      expect_sig(2, 32'h43, "pr_vec_no_preempt");
      rd(ADDR_PEND, 32'h0000_008A, "pr_pend_during_req");
      ack();
      expect_sig(1, 32'h0, "pr_irq_gap");
      rd(ADDR_PEND, 32'h0000_0082, "pr_pend_after_ack");
      chk(1, 32'h0, "pr_irq_idle");
      expect_sig(2, 32'h41, "pr_vec_second");
      tick();
      ack();
      chk(1, 32'h0, "pr_irq_gap2");
      chk(1, 32'h0, "pr_irq_idle2");
      expect_sig(2, 32'h47, "pr_vec_third");
      tick();
      ack();
      wait_n(2);
      rd(ADDR_PEND, 32'h0, "pr_pend_all_clear");
      chk(1, 32'h0, "pr_irq_done");
      pin_in[7] = 1'b0;
      pin_in[3] = 1'b0;
      pin_in[1] = 1'b0;
      wr(ADDR_IRQ_EN, 32'h0);
      wait_n(3);

      // Debounce
`ifdef GPIO_IRQ_DEBOUNCE_EN
      wr(ADDR_DEB_THR, 32'h3);
      wr(ADDR_DEB_EN, 32'h1);
      rd(ADDR_DEB_THR, 32'h3, "deb_thr_readback");
      rd(ADDR_DEB_EN, 32'h1, "deb_en_readback");
      pin_in[0] = 1'b1;
      wait_n(3);
      rd(ADDR_RAW, 32'h1, "deb_raw_high");
      rd(ADDR_IN, 32'h0, "deb_in_no_ping");
      ping();
      ping();
      rd(ADDR_IN, 32'h0, "deb_in_2ping");
      pin_in[0] = 1'b0;
      wait_n(3);
      rd(ADDR_IN, 32'h0, "deb_in_low");
      pin_in[0] = 1'b1;
      wait_n(3);
      ping();
      ping();
      rd(ADDR_IN, 32'h0, "deb_in_2of3");
      ping();
      rd(ADDR_IN, 32'h1, "deb_in_3ping");
      pin_in[0] = 1'b0;
      wait_n(3);
      wr(ADDR_DEB_EN, 32'h0);
      rd(ADDR_IN, 32'h0, "deb_in_disabled");
`else
      wr(ADDR_DEB_THR, 32'h3);
      wr(ADDR_DEB_EN, 32'h1);
      rd(ADDR_DEB_THR, 32'h0, "nodeb_thr_zero");
      rd(ADDR_DEB_EN, 32'h0, "nodeb_en_zero");
      pin_in[0] = 1'b1;
      wait_n(3);
      rd(ADDR_IN, 32'h1, "nodeb_in_direct");
      pin_in[0] = 1'b0;
      wait_n(3);
      rd(ADDR_IN, 32'h0, "nodeb_in_low");
`endif

      // W1C race and withdraw on pin 2
      wr(ADDR_IRQ_EN, 32'h0000_0004);
      pin_in[2] = 1'b1;
      irq_q.push_back(8'h42);
      wait_n(4);
      chk(1, 32'h1, "w1c_irq_pin2");
      pin_in[2] = 1'b0;
      wait_n(3);
      pin_in[2] = 1'b1;
      wait_n(2);
      wr(ADDR_PEND, 32'h0000_0004);
      expect_sig(1, 32'h1, "w1c_irq_held_race");
      rd(ADDR_PEND, 32'h0000_0004, "w1c_set_wins");
      wr(ADDR_PEND, 32'h0000_0004);
      expect_sig(1, 32'h1, "w1c_irq_before_withdraw");
      rd(ADDR_PEND, 32'h0, "w1c_pend_cleared");
      chk(1, 32'h0, "w1c_irq_withdrawn");
      wait_n(3);
      chk(1, 32'h0, "w1c_idle_after_withdraw");
      pin_in[2] = 1'b0;
      wr(ADDR_IRQ_EN, 32'h0);
      wait_n(3);

      // Level mode and vector wrap on pin 31
      wr(ADDR_VEC_BASE, 32'h0000_00F0);
      wr(ADDR_MODE0, 32'h8000_0000);
      wr(ADDR_MODE1, 32'h8000_0000);
      wr(ADDR_IRQ_EN, 32'h8000_0000);
      pin_in[31] = 1'b1;
      irq_q.push_back(8'h0F);
      wait_n(4);
      chk(2, 32'h0F, "lvl_vec_wrap");
      irq_q.push_back(8'h0F);
      ack();
      expect_sig(1, 32'h0, "lvl_irq_gap");
      rd(ADDR_PEND, 32'h8000_0000, "lvl_pend_after_ack");
      chk(1, 32'h0, "lvl_irq_idle");
      expect_sig(1, 32'h1, "lvl_irq_again");
      chk(2, 32'h0F, "lvl_vec_again");
      reset = 1'b1;
      #1;
      expect_sig(1, 32'h0, "lvl_irq_async_reset");
      rd(ADDR_PEND, 32'h0, "lvl_pend_async_reset");
      reset = 1'b0;
      chk(1, 32'h0, "lvl_irq_after_reset");
      rd(ADDR_IRQ_EN, 32'h0, "lvl_irq_en_after_reset");
      pin_in[31] = 1'b0;
      wait_n(3);

      n_checks++;
      if (irq_q.size() != 0) begin
         n_errors++;
         $display("FAIL irq_missing: %0d interrupts outstanding, required 0", irq_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

Parametrised pin-I/O and interrupt controller: a register-mapped bank of up to 32 bidirectional pins. Each pin has a per-pin output-enable and input polarity, and the low channels have optional tick-based debounce. Each pin also has a per-pin edge/level interrupt mode with W1C pending bits. A priority-encoded vector is presented to the CPU through a req/ack handshake. It sits between the external pin pads and the CPU register bus, in the same slot as the fixed-width pin/status register files it succeeds.

## Interface
- `WIDTH`, 32: pin count, 1..32; bus is 32 bits and unused upper bits read 0, writes ignored.
- `DEB_CH`, 4: number of low pins with debounce hardware, 0..WIDTH.
- `DEB_CNT_W`, 4: debounce counter/threshold width.
- `sysclk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pin_in` in WIDTH: raw pad inputs, asynchronous.
- `pin_out` out WIDTH: OUT register.
- `pin_oe_n` out WIDTH: ~DIR.
- `debct_ping` in 1: debounce tick, one-cycle pulse.
- `wr_n` in 1: active-low write strobe.
- `rd_n` in 1: active-low read strobe.
- `addr` in 4: register select.
- `din` in 32: write data.
- `dout` out 32: read data when rd_n=0, else all ones (combinational).
- `irq` out 1: interrupt request.
- `irq_vec` out 8: VEC_BASE + pin index; valid while irq=1.
- `irq_ack` in 1: one-cycle acknowledge.

## Operation
- Registers are all RW except where noted. Reset value is 0 unless noted.
  - 0 OUT
  - 1 DIR (1 = drive)
  - 2 INV
  - 3 DEB_EN
  - 4 IRQ_EN
  - 5 MODE0
  - 6 MODE1
  - 7 PEND (W1C)
  - 8 IN (RO, conditioned)
  - 9 RAW (RO, synchronised)
  - 10 VEC_BASE (bits 7:0)
  - 11 DEB_THR (DEB_CNT_W bits, reset all ones)
  - 12..15: read 0, writes ignored.
- Input path:
  - Two-flop synchroniser, then XOR with INV, giving `cond`.
  - For pin i < DEB_CH with DEB_EN[i]=1, `IN[i]` is the debounced stable value; otherwise `IN[i] = cond[i]`.
- Debounce, per channel:
  - If cond equals stable, the counter clears.
  - Otherwise, on each debct_ping the counter increments.
  - When the counter reaches max(DEB_THR,1), stable takes cond and the counter clears.
  - Clearing DEB_EN[i] clears the counter and loads stable from cond next cycle.
- Event per pin, on IN versus its registered previous value. Mode is {MODE1,MODE0}:
  - 00: rise
  - 01: fall
  - 10: both edges
  - 11: level-high, re-asserting every cycle IN=1
- Pending:
  - `PEND[i]` is set on event & IRQ_EN[i].
  - Writing 1 clears the bit.
  - On a simultaneous set and clear in one cycle, set wins.
  - IRQ_EN=0 does not clear PEND.
- Vector FSM:
  - IDLE: if any PEND & IRQ_EN, latch lowest such index, then go to REQ.
  - REQ: irq=1 and irq_vec held constant.
    - On irq_ack: clear PEND[idx], then go to GAP.
    - If PEND[idx] or IRQ_EN[idx] drops without ack: go to GAP (withdrawn).
    - A higher-priority arrival in REQ does not preempt.
  - GAP: irq=0 for one cycle, then go to IDLE.
  - irq_ack outside REQ is ignored.
  - Ack and a W1C of the same bit in one cycle: single clear, go to GAP.
- Vector arithmetic: irq_vec = VEC_BASE + idx, 8-bit, wraps modulo 256.

## Timing
- Reset values:
  - pin_out=0, pin_oe_n all ones.
  - irq=0, irq_vec=0, FSM in IDLE.
  - Synchroniser, prev, stable and counters all 0.
- Writes take effect at the sysclk edge with wr_n=0. Reads are combinational.
- Latency, with pin_in changing before edge k:
  - RAW/IN updates after edge k+1 (no debounce).
  - PEND sets at edge k+2.
  - irq rises at edge k+3.
- With debounce enabled, add the tick-qualified count.
- irq falls the edge after ack. The earliest next irq is 2 edges after ack (GAP).
- Reset mid-REQ drops irq and clears PEND immediately, asynchronously.

## Configuration
- `GPIO_IRQ_DEBOUNCE_EN` defined: debounce channels are built as above.
- Undefined:
  - No counters are built.
  - DEB_EN and DEB_THR read 0 and writes are ignored.
  - IN = cond for all pins.
  - debct_ping is unused.

## Structure
- Package `gpio_irq_pkg` holds:
  - register address localparams
  - mode encoding (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL)
  - FSM state enum (IDLE, REQ, GAP)
- One sub-module, `gpio_irq_debounce`: a single channel (cond, tick, enable, threshold → stable), instantiated DEB_CH times via generate.
- The priority encoder stays inline.

## Test plan
- Reset:
  - Stimulus: read all registers.
  - Required: DEB_THR=all ones, the rest 0; pin_oe_n=all ones; irq=0.
- Rising edge on pin 5:
  - Stimulus: IRQ_EN=0x20, MODE=00, VEC_BASE=0x40; pin_in[5] 0→1.
  - Required: PEND=0x20 at edge k+2; irq=1 with irq_vec=0x45 at k+3; irq_ack → PEND=0, irq=0, no reassert.
- Priority and no-preempt:
  - Stimulus: pins 7 and 3 pend together.
  - Required: vec=base+3.
  - Stimulus: pin 1 then pends during REQ.
  - Required: vec stays 3; after ack and GAP, vec=base+1, then base+7.
- Debounce:
  - Stimulus: DEB_EN[0]=1, DEB_THR=3; pin_in[0] high for 2 pings, low, then high for 3 pings.
  - Required: IN[0] rises only after the third consecutive ping.
- W1C race and withdraw:
  - Stimulus: W1C on PEND[2] in the same cycle as a new edge on pin 2.
  - Required: PEND[2] stays 1.
  - Stimulus: W1C of the latched bit during REQ.
  - Required: irq drops, GAP, IDLE.
- Level mode and wrap:
  - Stimulus: MODE=11, pin 31 held high, VEC_BASE=0xF0.
  - Required: vec=0x0F; PEND re-sets after each ack while the pin is high; asynchronous reset mid-REQ drops irq the same cycle.
